// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// default clock/bit-rate constants used by both the transmitter and receiver.
package uart_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 115200;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  function automatic int baud_div(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is
// a parameter so an idle-high line does not look like activity after reset.
module uart_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver: synchronises the line, centre-samples each bit with an
// integer baud divider and emits one-cycle rx_valid / frame_err strobes.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   uart_rx,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   frame_err,
  output logic                   rx_busy
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = $clog2(BAUD_DIV);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_DIV - 1);

  generate
    if (BAUD_DIV < 16) begin : g_div_check
      $error("uart_rx_byte: BAUD_DIV must be at least 16");
    end
  endgenerate

  logic sync_q;
  logic prev_q;
  logic fall;

  rx_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;

  uart_sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk_i (sys_clk),
    .rst_ni(rst_n),
    .d_i   (uart_rx),
    .q_o   (sync_q)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= sync_q;
    end
  end

  assign fall = prev_q & ~sync_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_FULL) ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // A line that is high again at the start-bit centre was only a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!sync_q) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          shift_d = {sync_q, shift_q[UART_DATA_W-1:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
            cnt_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        // Leaving at the stop-bit centre lets a back-to-back start edge be seen.
        if (cnt_q == CNT_FULL) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (sync_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    shift_q <= shift_d;
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scenario bench for uart_rx_byte: a serial line driver pushes expected bytes
// into a scoreboard queue, a monitor records what the receiver produces.
module tb_uart_rx_byte;

  localparam int CLK_PERIOD = 20;
  localparam int BIT_CLKS   = 434;
  localparam int LATENCY    = 4124;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  longint     rx_t[$];
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         busy_cnt = 0;
  int         rd_idx = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx_byte dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #(CLK_PERIOD/2) sys_clk = ~sys_clk;

  // Monitor: outputs are sampled on the falling edge, mid-cycle.
  always @(negedge sys_clk) begin
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      rx_t.push_back($time);
    end
    if (frame_err) ferr_cnt++;
    if (rx_valid && frame_err) both_cnt++;
    if (rx_busy) busy_cnt++;
  end

  task automatic bit_time(input logic v);
    uart_rx = v;
    repeat (BIT_CLKS) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) begin
      exp_q.push_back(b);
      last_good = b;
    end
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_bit);
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (rx_data !== 8'h00) begin
      errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data);
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err);
    end
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy);
    end
    #(201 - $time);
    rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge sys_clk);
  endtask

  task automatic test_single;
    int     n0, f0;
    longint t_fall, lat;
    logic [7:0] exp;
    n0 = rx_q.size();
    f0 = ferr_cnt;
    t_fall = $time;
    send_frame(8'h55, 1'b1);
    bit_time(1'b1);
    checks++;
    if (rx_q.size() - n0 !== 1) begin
      errors++; $display("FAIL single_count: got %0d pulses expected 1", rx_q.size() - n0);
    end
    checks++;
    if (ferr_cnt - f0 !== 0) begin
      errors++; $display("FAIL single_ferr: got %0d pulses expected 0", ferr_cnt - f0);
    end
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++;
      if (rd_idx >= rx_q.size()) begin
        errors++; $display("FAIL single_data: got nothing expected %h", exp);
      end else if (rx_q[rd_idx] !== exp) begin
        errors++; $display("FAIL single_data: got %h expected %h", rx_q[rd_idx], exp);
      end
      rd_idx++;
    end
    if (rx_q.size() > n0) begin
      lat = (rx_t[n0] - CLK_PERIOD/2 - t_fall) / CLK_PERIOD;
      checks++;
      if (lat < LATENCY - 1 || lat > LATENCY + 1) begin
        errors++; $display("FAIL single_latency: got %0d clocks expected %0d+-1", lat, LATENCY);
      end
    end
    rd_idx = rx_q.size();
  endtask

  task automatic test_loopback;
    int         f0, n0;
    logic [7:0] exp;
    f0 = ferr_cnt;
    n0 = rx_q.size();
    for (int i = 0; i < 6; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    bit_time(1'b1);
    checks++;
    if (rx_q.size() - n0 !== 6) begin
      errors++; $display("FAIL loop_count: got %0d pulses expected 6", rx_q.size() - n0);
    end
    checks++;
    if (ferr_cnt - f0 !== 0) begin
      errors++; $display("FAIL loop_ferr: got %0d pulses expected 0", ferr_cnt - f0);
    end
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++;
      if (rd_idx >= rx_q.size()) begin
        errors++; $display("FAIL loop_data: got nothing expected %h", exp);
      end else if (rx_q[rd_idx] !== exp) begin
        errors++; $display("FAIL loop_data: got %h expected %h", rx_q[rd_idx], exp);
      end
      rd_idx++;
    end
    rd_idx = rx_q.size();
  endtask

  task automatic test_back_to_back;
    int         n0;
    longint     gap;
    logic [7:0] exp;
    n0 = rx_q.size();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    bit_time(1'b1);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++;
      if (rd_idx >= rx_q.size()) begin
        errors++; $display("FAIL b2b_data: got nothing expected %h", exp);
      end else if (rx_q[rd_idx] !== exp) begin
        errors++; $display("FAIL b2b_data: got %h expected %h", rx_q[rd_idx], exp);
      end
      rd_idx++;
    end
    checks++;
    if (rx_q.size() - n0 !== 2) begin
      errors++; $display("FAIL b2b_count: got %0d pulses expected 2", rx_q.size() - n0);
    end else begin
      gap = (rx_t[n0+1] - rx_t[n0]) / CLK_PERIOD;
      checks++;
      if (gap < 10*BIT_CLKS - 1 || gap > 10*BIT_CLKS + 1) begin
        errors++; $display("FAIL b2b_spacing: got %0d clocks expected %0d", gap, 10*BIT_CLKS);
      end
    end
    rd_idx = rx_q.size();
  endtask

  task automatic test_break;
    int n0, f0, busy_hi;
    n0 = rx_q.size();
    f0 = ferr_cnt;
    busy_hi = 0;
    send_frame(8'hFF, 1'b0);
    uart_rx = 1'b0;
    for (int i = 0; i < 3 * BIT_CLKS; i++) begin
      @(negedge sys_clk);
      if (rx_busy) busy_hi++;
    end
    uart_rx = 1'b1;
    for (int i = 0; i < BIT_CLKS; i++) begin
      @(negedge sys_clk);
      if (rx_busy) busy_hi++;
    end
    checks++;
    if (ferr_cnt - f0 !== 1) begin
      errors++; $display("FAIL break_ferr: got %0d pulses expected 1", ferr_cnt - f0);
    end
    checks++;
    if (rx_q.size() - n0 !== 0) begin
      errors++; $display("FAIL break_valid: got %0d pulses expected 0", rx_q.size() - n0);
    end
    checks++;
    if (rx_data !== last_good) begin
      errors++; $display("FAIL break_rx_data: got %h expected %h", rx_data, last_good);
    end
    checks++;
    if (busy_hi !== 0) begin
      errors++; $display("FAIL break_busy: got %0d busy cycles expected 0", busy_hi);
    end
    rd_idx = rx_q.size();
  endtask

  task automatic test_glitch;
    int n0, f0, b0, busy_len;
    n0 = rx_q.size();
    f0 = ferr_cnt;
    b0 = busy_cnt;
    uart_rx = 1'b0;
    repeat (5) @(negedge sys_clk);
    uart_rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge sys_clk);
    busy_len = busy_cnt - b0;
    checks++;
    if (busy_len < 214 || busy_len > 220) begin
      errors++; $display("FAIL glitch_busy: got %0d cycles expected 217+-3", busy_len);
    end
    checks++;
    if (rx_q.size() - n0 !== 0 || ferr_cnt - f0 !== 0) begin
      errors++; $display("FAIL glitch_pulse: got valid=%0d ferr=%0d expected 0/0",
                         rx_q.size() - n0, ferr_cnt - f0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int         n0, f0;
    logic [7:0] b, exp;
    b  = 8'h3C;
    n0 = rx_q.size();
    f0 = ferr_cnt;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(b[i]);
    uart_rx = b[4];
    repeat (200) @(negedge sys_clk);
    rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    checks++;
    if ({rx_data, rx_valid, frame_err, rx_busy} !== 11'h000) begin
      errors++; $display("FAIL midreset_outputs: got data=%h v=%b fe=%b busy=%b expected all 0",
                         rx_data, rx_valid, frame_err, rx_busy);
    end
    repeat (BIT_CLKS - 202) @(negedge sys_clk);
    for (int i = 5; i < 8; i++) bit_time(b[i]);
    bit_time(1'b1);
    bit_time(1'b1);
    checks++;
    if ({rx_data, rx_valid, frame_err, rx_busy} !== 11'h000) begin
      errors++; $display("FAIL midreset_hold: got data=%h v=%b fe=%b busy=%b expected all 0",
                         rx_data, rx_valid, frame_err, rx_busy);
    end
    rst_n = 1'b1;
    bit_time(1'b1);
    bit_time(1'b1);
    checks++;
    if (rx_q.size() - n0 !== 0 || ferr_cnt - f0 !== 0) begin
      errors++; $display("FAIL midreset_aborted: got valid=%0d ferr=%0d expected 0/0",
                         rx_q.size() - n0, ferr_cnt - f0);
    end
    send_frame(8'hC3, 1'b1);
    bit_time(1'b1);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++;
      if (rd_idx >= rx_q.size()) begin
        errors++; $display("FAIL midreset_data: got nothing expected %h", exp);
      end else if (rx_q[rd_idx] !== exp) begin
        errors++; $display("FAIL midreset_data: got %h expected %h", rx_q[rd_idx], exp);
      end
      rd_idx++;
    end
    checks++;
    if (rx_q.size() - n0 !== 1) begin
      errors++; $display("FAIL midreset_count: got %0d pulses expected 1", rx_q.size() - n0);
    end
    rd_idx = rx_q.size();
  endtask

  initial begin
    test_reset();
    test_single();
    test_loopback();
    test_back_to_back();
    test_break();
    test_glitch();
    test_reset_mid_frame();
    checks++;
    if (both_cnt !== 0) begin
      errors++; $display("FAIL exclusive_strobes: got %0d overlapping cycles expected 0", both_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
